md_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer in the E stage of the P5 pipelined CPU. It sits beside the single-cycle ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and runs a fixed-latency operation.
- Owns the architectural HI/LO registers.
- Drives a busy flag that the hazard unit combines with the D-stage mfhi/mflo/md-op decode to stall the pipeline.

---
 rtl/md_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_md_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide sequencer for the E stage.
// Owns architectural HI/LO. mult/multu/div/divu compute their result into
// shadow registers on the start edge, hold busy for a fixed latency, then
// commit to HI/LO. mthi/mtlo write directly while idle.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high clear of all state
//   MD_start_E_i  one-cycle request from the E stage
//   MD_op_E_i     000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   MD_srca_E_i   rs operand (dividend / multiplicand / mthi-mtlo data)
//   MD_srcb_E_i   rt operand (divisor / multiplier)
//   MD_busy_E_o   registered busy flag, high for exactly the op latency
//   MD_hi_o       architectural HI
//   MD_lo_o       architectural LO
module md_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MD_start_E_i,
    input  logic [2:0]  MD_op_E_i,
    input  logic [31:0] MD_srca_E_i,
    input  logic [31:0] MD_srcb_E_i,
    output logic        MD_busy_E_o,
    output logic [31:0] MD_hi_o,
    output logic [31:0] MD_lo_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  sh;
    logic [DATA_W-1:0]  sl;
    logic               keep_hilo;   // divide by zero: commit leaves HI/LO alone

    // Control strobes from the output decode
    logic               accept_md;
    logic               write_hi;
    logic               write_lo;
    logic               commit;

    // Arithmetic results for the op presented on the inputs
    logic [PROD_W-1:0]  mul_a;
    logic [PROD_W-1:0]  mul_b;
    logic [PROD_W-1:0]  mul_res;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [DATA_W-1:0]  a_mag;
    logic [DATA_W-1:0]  b_mag;
    logic [DATA_W-1:0]  b_safe;
    logic [DATA_W-1:0]  q_mag;
    logic [DATA_W-1:0]  r_mag;
    logic [DATA_W-1:0]  div_q;
    logic [DATA_W-1:0]  div_r;
    logic               div_zero;
    logic [DATA_W-1:0]  res_hi;
    logic [DATA_W-1:0]  res_lo;
    logic [CNT_W-1:0]   lat_sel;

    logic               is_md_op;
    logic               last_cycle;

    assign is_md_op   = MD_start_E_i && (MD_op_E_i[2] == 1'b0);
    assign last_cycle = (cnt == CNT_W'(1));

    // Multiplier: sign/zero-extend to 64 bits; the low 64 bits of the
    // product are the correct two's-complement result either way.
    always_comb begin
        mul_a = {{DATA_W{1'b0}}, MD_srca_E_i};
        mul_b = {{DATA_W{1'b0}}, MD_srcb_E_i};
        if (MD_op_E_i == OP_MULT) begin
            mul_a = {{DATA_W{MD_srca_E_i[DATA_W-1]}}, MD_srca_E_i};
            mul_b = {{DATA_W{MD_srcb_E_i[DATA_W-1]}}, MD_srcb_E_i};
        end
        mul_res = mul_a * mul_b;
    end

    // Divider: unsigned magnitude divide, then restore signs.
    // Quotient truncates toward zero; remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0.
    always_comb begin
        div_signed = (MD_op_E_i == OP_DIV);
        a_neg      = div_signed && MD_srca_E_i[DATA_W-1];
        b_neg      = div_signed && MD_srcb_E_i[DATA_W-1];
        a_mag      = a_neg ? DATA_W'(-MD_srca_E_i) : MD_srca_E_i;
        b_mag      = b_neg ? DATA_W'(-MD_srcb_E_i) : MD_srcb_E_i;
        div_zero   = (MD_srcb_E_i == '0);
        b_safe     = div_zero ? DATA_W'(1) : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        div_q      = (a_neg ^ b_neg) ? DATA_W'(-q_mag) : q_mag;
        div_r      = a_neg ? DATA_W'(-r_mag) : r_mag;
    end

    // Result and latency selection by op class
    always_comb begin
        if (MD_op_E_i[1]) begin
            res_hi  = div_r;
            res_lo  = div_q;
            lat_sel = CNT_W'(DIV_LAT);
        end else begin
            res_hi  = mul_res[PROD_W-1:DATA_W];
            res_lo  = mul_res[DATA_W-1:0];
            lat_sel = CNT_W'(MULT_LAT);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (is_md_op) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_cycle) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output/strobe decode; starts during RUN are dropped here
    always_comb begin
        accept_md = 1'b0;
        write_hi  = 1'b0;
        write_lo  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (MD_start_E_i) begin
                    case (MD_op_E_i)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: accept_md = 1'b1;
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                commit = last_cycle;
            end
            default: ;
        endcase
    end

    // Counter, shadow results and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            sh          <= '0;
            sl          <= '0;
            keep_hilo   <= 1'b0;
            MD_busy_E_o <= 1'b0;
        end else begin
            if (accept_md) begin
                cnt         <= lat_sel;
                sh          <= res_hi;
                sl          <= res_lo;
                keep_hilo   <= MD_op_E_i[1] && div_zero;
                MD_busy_E_o <= 1'b1;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
                if (commit) begin
                    MD_busy_E_o <= 1'b0;
                end
            end
        end
    end

    // Architectural HI/LO: written by commit or by mthi/mtlo while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MD_hi_o <= '0;
            MD_lo_o <= '0;
        end else begin
            if (commit && !keep_hilo) begin
                MD_hi_o <= sh;
                MD_lo_o <= sl;
            end
            if (write_hi) begin
                MD_hi_o <= MD_srca_E_i;
            end
            if (write_lo) begin
                MD_lo_o <= MD_srca_E_i;
            end
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl. Issued ops push their expected
// HI/LO and latency; a monitor pops on each busy falling edge and compares.
module tb_md_ctrl;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    typedef struct {
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          failures;
    int          cyc;
    int          free_at;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    exp_t        sbq[$];

    md_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MD_start_E_i(start),
        .MD_op_E_i   (op),
        .MD_srca_E_i (srca),
        .MD_srcb_E_i (srcb),
        .MD_busy_E_o (busy),
        .MD_hi_o     (hi),
        .MD_lo_o     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // Reference arithmetic from the instruction definitions
    function automatic void model_md(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] h, inout logic [31:0] l);
        longint      ps;
        logic [63:0] pu;
        int          sa;
        int          sb;
        case (mop)
            3'd0: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                pu = 64'(ps);
                h  = pu[63:32];
                l  = pu[31:0];
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                h  = pu[63:32];
                l  = pu[31:0];
            end
            3'd2: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        l = 32'h8000_0000;
                        h = 32'd0;
                    end else begin
                        sa = $signed(a);
                        sb = $signed(b);
                        l  = 32'(sa / sb);
                        h  = 32'(sa % sb);
                    end
                end
            end
            3'd3: begin
                if (b != 0) begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor: HI/LO must hold during busy; each busy fall retires one op
    int   bcnt;
    logic pbusy;
    initial begin
        bcnt  = 0;
        pbusy = 1'b0;
    end
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bcnt  = 0;
            pbusy = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
                if (sbq.size() > 0) begin
                    chk("hold_hi", hi, sbq[0].old_hi);
                    chk("hold_lo", lo, sbq[0].old_lo);
                end else begin
                    chk("busy_without_op", 32'(busy), 32'd0);
                end
            end else if (pbusy) begin
                if (sbq.size() == 0) begin
                    fail_now("commit_without_op");
                end else begin
                    e = sbq.pop_front();
                    chk("busy_cycles", 32'(bcnt), 32'(e.lat));
                    chk("commit_hi", hi, e.new_hi);
                    chk("commit_lo", lo, e.new_lo);
                end
                bcnt = 0;
            end
            pbusy = busy;
        end
    end

    task automatic idle_slot();
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        srca  = $urandom;
        srcb  = $urandom;
    endtask

    task automatic issue(input logic [2:0] iop, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] h;
        logic [31:0] l;
        logic        acc;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = iop;
        srca  = a;
        srcb  = b;
        acc   = (cyc >= free_at);
        if (acc && iop <= 3'd3) begin
            h = m_hi;
            l = m_lo;
            model_md(iop, a, b, h, l);
            e.old_hi = m_hi;
            e.old_lo = m_lo;
            e.new_hi = h;
            e.new_lo = l;
            e.lat    = iop[1] ? int'(DIV_LAT) : int'(MULT_LAT);
            sbq.push_back(e);
            m_hi    = h;
            m_lo    = l;
            free_at = cyc + 1 + e.lat;
        end else if (acc && (iop == 3'd4 || iop == 3'd5)) begin
            if (iop == 3'd4) m_hi = a;
            else             m_lo = a;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("mt_hi", hi, m_hi);
            chk("mt_lo", lo, m_lo);
            chk("mt_busy", 32'(busy), 32'd0);
        end
    endtask

    // Advance until the model says the unit is free and busy is low
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!(cyc >= free_at && busy == 1'b0) && n < 300);
        if (n >= 300) fail_now("wait_idle_timeout");
    endtask

    task automatic expect_hl(input string name, input logic [31:0] h, input logic [31:0] l);
        chk({name, "_hi"}, hi, h);
        chk({name, "_lo"}, lo, l);
    endtask

    function automatic logic [31:0] pick(input int zero_bias);
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < zero_bias) return 32'd0;
        case (sel)
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        free_at  = 0;
        m_hi     = '0;
        m_lo     = '0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = '0;
        srca     = '0;
        srcb     = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        expect_hl("rst", 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        free_at = cyc;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        expect_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd3, 32'd100, 32'd7);
        wait_idle();
        expect_hl("divu", 32'd2, 32'd14);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        expect_hl("div_ovf", 32'd0, 32'h8000_0000);

        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle();
        expect_hl("div0", 32'h11, 32'h22);

        // Starts during RUN are dropped; mthi in first idle cycle lands
        issue(3'd0, 32'd6, 32'd7);
        issue(3'd5, 32'hAA, 32'd0);
        issue(3'd0, 32'd2, 32'd2);
        wait_idle();
        expect_hl("ign", 32'd0, 32'd42);
        issue(3'd4, 32'h55, 32'd0);
        expect_hl("mthi_after", 32'h55, 32'd42);

        // Asynchronous reset two cycles into a div
        issue(3'd2, 32'd9, 32'd2);
        idle_slot();
        idle_slot();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        expect_hl("arst", 32'd0, 32'd0);
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        free_at = cyc;
        issue(3'd0, 32'd3, 32'd4);
        wait_idle();
        expect_hl("post_rst", 32'd0, 32'd12);

        // Random mix, including reserved ops and starts during RUN
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick(1);
            b = pick(3);
            issue(3'($urandom_range(0, 7)), a, b);
            repeat ($urandom_range(0, 12)) idle_slot();
        end

        wait_idle();
        repeat (3) idle_slot();
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        expect_hl("final", m_hi, m_lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
